// File: rtl/multicycle_controller.sv
// Control FSM for the 32-bit multi-cycle MIPS datapath.
// It takes one state per clock and drives every datapath strobe, select and ALU operation.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic [5:0] Function,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] RegDst,
    output logic [1:0] MemToReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUOperation,
    output logic       InstrDone
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13
    } state_t;

    state_t state, state_next;

    logic is_jr;
    logic funct_ok;
    logic instr_legal;

    assign is_jr    = (Opcode == OP_R) && (Function == FN_JR);
    assign funct_ok = Function inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    assign instr_legal = (Opcode == OP_R) ? (funct_ok || is_jr)
                       : (Opcode inside {OP_LW, OP_SW, OP_BEQ, OP_BNE,
                                         OP_ADDI, OP_SLTI, OP_J, OP_JAL});

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: a default before the case keeps combinational blocks free of inferred latches.
        state_next = S_FETCH;
        case (state)
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                if (!instr_legal)              state_next = S_FETCH;
                else if (is_jr)                state_next = S_JR;
                else if (Opcode == OP_R)       state_next = S_R_EXEC;
                else begin
                    case (Opcode)
                        OP_LW, OP_SW:     state_next = S_MEM_ADDR;
                        OP_BEQ, OP_BNE:   state_next = S_BRANCH;
                        OP_ADDI, OP_SLTI: state_next = S_I_EXEC;
                        OP_J:             state_next = S_JUMP;
                        OP_JAL:           state_next = S_JAL;
                        default:          state_next = S_FETCH;
                    endcase
                end
            end
            S_MEM_ADDR: state_next = (Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: state_next = S_MEM_WB;
            S_R_EXEC:   state_next = S_R_WB;
            S_I_EXEC:   state_next = S_I_WB;
            default:    state_next = S_FETCH;
        endcase
    end

    // Outputs are gated by rst_n so an asserted reset silences every strobe mid-cycle.
    always_comb begin
        PCWrite      = 1'b0;
        IorD         = 1'b0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        RegDst       = 2'd0;
        MemToReg     = 2'd0;
        ALUSrcB      = 2'd0;
        PCSrc        = 2'd0;
        ALUOperation = ALU_AND;
        InstrDone    = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    MemRead      = 1'b1;
                    IRWrite      = 1'b1;
                    ALUSrcB      = 2'd1;
                    ALUOperation = ALU_ADD;
                    PCWrite      = 1'b1;
                end
                S_DECODE: begin
                    ALUSrcB      = 2'd3;
                    ALUOperation = ALU_ADD;
                    InstrDone    = !instr_legal;
                end
                S_MEM_ADDR: begin
                    ALUSrcA      = 1'b1;
                    ALUSrcB      = 2'd2;
                    ALUOperation = ALU_ADD;
                end
                S_MEM_READ: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEM_WB: begin
                    RegWrite  = 1'b1;
                    MemToReg  = 2'd1;
                    InstrDone = 1'b1;
                end
                S_MEM_WRITE: begin
                    MemWrite  = 1'b1;
                    IorD      = 1'b1;
                    InstrDone = 1'b1;
                end
                S_R_EXEC: begin
                    ALUSrcA = 1'b1;
                    case (Function)
                        FN_ADD:  ALUOperation = ALU_ADD;
                        FN_SUB:  ALUOperation = ALU_SUB;
                        FN_OR:   ALUOperation = ALU_OR;
                        FN_SLT:  ALUOperation = ALU_SLT;
                        default: ALUOperation = ALU_AND;
                    endcase
                end
                S_R_WB: begin
                    RegWrite  = 1'b1;
                    RegDst    = 2'd1;
                    InstrDone = 1'b1;
                end
                S_I_EXEC: begin
                    ALUSrcA      = 1'b1;
                    ALUSrcB      = 2'd2;
                    ALUOperation = (Opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                end
                S_I_WB: begin
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA      = 1'b1;
                    ALUOperation = ALU_SUB;
                    PCSrc        = 2'd2;
                    PCWrite      = (Opcode == OP_BNE) ? !Zero : Zero;
                    InstrDone    = 1'b1;
                end
                S_JUMP: begin
                    PCSrc     = 2'd1;
                    PCWrite   = 1'b1;
                    InstrDone = 1'b1;
                end
                S_JAL: begin
                    PCSrc     = 2'd1;
                    PCWrite   = 1'b1;
                    RegWrite  = 1'b1;
                    RegDst    = 2'd2;
                    MemToReg  = 2'd2;
                    InstrDone = 1'b1;
                end
                S_JR: begin
                    ALUSrcA      = 1'b1;
                    ALUOperation = ALU_ADD;
                    PCWrite      = 1'b1;
                    InstrDone    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
